// File: rtl/cpu_defs.sv
// Constants shared by the register file, the ALU and their benches, so operand
// widths stay in lock-step across the datapath.
package cpu_defs;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  // ALU function select driven alongside DATA1/DATA2
  typedef enum logic [2:0] {
    AluFwd = 3'b000,
    AluAdd = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011
  } alu_sel_e;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: indexes the storage array, with optional
// write-forwarding and a hardwired-zero register 0.
module reg_read_port
  import cpu_defs::*;
#(
  parameter int unsigned DATA_W   = cpu_defs::DATA_W,
  parameter int unsigned ADDR_W   = cpu_defs::ADDR_W,
  parameter int unsigned DEPTH    = cpu_defs::DEPTH,
  parameter int unsigned BYPASS   = 0,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]            raddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic                         wr_fwd,
  output logic [DATA_W-1:0]            rdata
);

  always_comb begin
    rdata = regs[raddr];
    if (BYPASS != 0 && wr_fwd && raddr == waddr) begin
      rdata = wdata;
    end
    // Hardwired zero takes priority over forwarding
    if (ZERO_REG != 0 && raddr == '0) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Operand register file: two combinational read ports feeding the ALU and one
// synchronous write port capturing the ALU result.
module reg_file
  import cpu_defs::*;
#(
  parameter int unsigned DATA_W   = cpu_defs::DATA_W,
  parameter int unsigned ADDR_W   = cpu_defs::ADDR_W,
  parameter int unsigned DEPTH    = cpu_defs::DEPTH,
  parameter int unsigned BYPASS   = 0,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2
);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic                         wr_en;
  logic                         wr_fwd;

  // Forwarding is only meaningful while the write will actually be taken
  assign wr_fwd = WRITE & ~RESET;
  assign wr_en  = WRITE & ~(ZERO_REG != 0 && INADDRESS == '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      regs_q <= '0;
    end else if (wr_en) begin
      regs_q[INADDRESS] <= IN;
    end
  end

  reg_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_port1 (
    .regs  (regs_q),
    .raddr (OUT1ADDRESS),
    .wdata (IN),
    .waddr (INADDRESS),
    .wr_fwd(wr_fwd),
    .rdata (OUT1)
  );

  reg_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_port2 (
    .regs  (regs_q),
    .raddr (OUT2ADDRESS),
    .wdata (IN),
    .waddr (INADDRESS),
    .wr_fwd(wr_fwd),
    .rdata (OUT2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: a plain instance and a BYPASS/ZERO_REG instance share
// stimulus; expectations are queued and checked by a separate monitor.
module tb_reg_file;
  import cpu_defs::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_drv;
  logic [7:0] in_bus;
  logic [2:0] in_addr;
  logic       wr;
  logic [2:0] a1;
  logic [2:0] a2;
  logic       alu_loop;
  logic [7:0] o1, o2, b1, b2;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(alu_sel_e s, logic [7:0] x, logic [7:0] y);
    case (s)
      AluFwd:  return y;
      AluAdd:  return x + y;
      AluAnd:  return x & y;
      AluOr:   return x | y;
      default: return 8'h00;
    endcase
  endfunction

  // Closed loop: operands from the register file through the ALU back to IN
  assign in_bus = alu_loop ? alu_model(AluAdd, o1, o2) : in_drv;

  reg_file #(.BYPASS(0), .ZERO_REG(0)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .IN         (in_bus),
    .INADDRESS  (in_addr),
    .WRITE      (wr),
    .OUT1ADDRESS(a1),
    .OUT2ADDRESS(a2),
    .OUT1       (o1),
    .OUT2       (o2)
  );

  reg_file #(.BYPASS(1), .ZERO_REG(1)) dut_b (
    .CLK        (clk),
    .RESET      (rst),
    .IN         (in_bus),
    .INADDRESS  (in_addr),
    .WRITE      (wr),
    .OUT1ADDRESS(a1),
    .OUT2ADDRESS(a2),
    .OUT1       (b1),
    .OUT2       (b2)
  );

  typedef struct {
    string       name;
    int unsigned port;
    logic [7:0]  exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event chk_ev;

  // port: 0 = dut OUT1, 1 = dut OUT2, 2 = dut_b OUT1, 3 = dut_b OUT2
  task automatic expect_val(string name, int unsigned port, logic [7:0] e);
    sb.push_back('{name: name, port: port, exp: e});
  endtask

  task automatic sample();
    ->chk_ev;
    #2;
  endtask

  task automatic wr_reg(logic [2:0] addr, logic [7:0] data);
    @(negedge clk);
    wr      = 1'b1;
    in_addr = addr;
    in_drv  = data;
    @(negedge clk);
    wr      = 1'b0;
  endtask

  initial begin : monitor
    exp_t       t;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      #1;
      while (sb.size() > 0) begin
        t = sb.pop_front();
        case (t.port)
          0:       act = o1;
          1:       act = o2;
          2:       act = b1;
          default: act = b2;
        endcase
        n_tests++;
        if (act !== t.exp) begin
          n_fail++;
          $display("FAIL %s (port %0d): got %h, expected %h", t.name, t.port, act, t.exp);
        end
      end
    end
  end

  initial begin : stim
    rst      = 1'b1;
    wr       = 1'b0;
    in_drv   = 8'h00;
    in_addr  = 3'd0;
    a1       = 3'd0;
    a2       = 3'd0;
    alu_loop = 1'b0;
    #12 rst  = 1'b0;

    // Preload every register so the reset clear is observable
    for (int i = 0; i < 8; i++) wr_reg(3'(i), 8'h10 + 8'(i));

    // Async reset mid-cycle clears outputs without a clock edge
    @(negedge clk);
    a1 = 3'd3;
    a2 = 3'd7;
    expect_val("preload_r3", 0, 8'h13);
    expect_val("preload_r7", 1, 8'h17);
    expect_val("preload_r3_b", 2, 8'h13);
    expect_val("preload_r7_b", 3, 8'h17);
    sample();
    rst = 1'b1;
    expect_val("async_rst_o1", 0, 8'h00);
    expect_val("async_rst_o2", 1, 8'h00);
    expect_val("async_rst_b1", 2, 8'h00);
    expect_val("async_rst_b2", 3, 8'h00);
    sample();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a1 = 3'(i);
      a2 = 3'(7 - i);
      expect_val("rst_clear_o1", 0, 8'h00);
      expect_val("rst_clear_o2", 1, 8'h00);
      sample();
    end

    // Successive writes, both ports read
    wr_reg(3'd1, 8'hFF);
    wr_reg(3'd2, 8'h01);
    a1 = 3'd1;
    a2 = 3'd2;
    expect_val("wr_r1", 0, 8'hFF);
    expect_val("wr_r2", 1, 8'h01);
    expect_val("wr_r1_b", 2, 8'hFF);
    expect_val("wr_r2_b", 3, 8'h01);
    sample();

    // WRITE low: nothing changes
    @(negedge clk);
    wr      = 1'b0;
    in_drv  = 8'h55;
    in_addr = 3'd3;
    repeat (3) @(negedge clk);
    a1 = 3'd3;
    a2 = 3'd1;
    expect_val("no_wr_r3", 0, 8'h00);
    expect_val("no_wr_r1", 1, 8'hFF);
    expect_val("no_wr_r3_b", 2, 8'h00);
    sample();

    // Read during write, same address
    wr_reg(3'd4, 8'h0A);
    wr      = 1'b1;
    in_drv  = 8'h0B;
    in_addr = 3'd4;
    a1      = 3'd4;
    a2      = 3'd3;
    expect_val("rdw_old", 0, 8'h0A);
    expect_val("rdw_bypass", 2, 8'h0B);
    expect_val("rdw_other_b", 3, 8'h00);
    sample();
    @(negedge clk);
    wr = 1'b0;
    expect_val("rdw_new", 0, 8'h0B);
    expect_val("rdw_new_b", 2, 8'h0B);
    sample();

    // Reset held across an edge beats a write; bypass suppressed during reset
    @(negedge clk);
    rst     = 1'b1;
    wr      = 1'b1;
    in_drv  = 8'h77;
    in_addr = 3'd5;
    a1      = 3'd5;
    a2      = 3'd1;
    expect_val("rst_wr_o1", 0, 8'h00);
    expect_val("rst_wr_o2", 1, 8'h00);
    expect_val("rst_no_bypass", 2, 8'h00);
    sample();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr  = 1'b0;
    a1  = 3'd5;
    a2  = 3'd4;
    expect_val("rst_blk_r5", 0, 8'h00);
    expect_val("rst_clr_r4", 1, 8'h00);
    expect_val("rst_blk_r5_b", 2, 8'h00);
    sample();

    // Closed loop through an ADD
    wr_reg(3'd1, 8'h55);
    wr_reg(3'd2, 8'h03);
    a1       = 3'd1;
    a2       = 3'd2;
    in_addr  = 3'd3;
    alu_loop = 1'b1;
    wr       = 1'b1;
    @(negedge clk);
    wr       = 1'b0;
    alu_loop = 1'b0;
    a1       = 3'd3;
    expect_val("loop_r3", 0, 8'h58);
    expect_val("loop_r3_b", 2, 8'h58);
    sample();

    // Register 0: zero-reg overrides bypass and discards the write
    @(negedge clk);
    wr      = 1'b1;
    in_drv  = 8'h12;
    in_addr = 3'd0;
    a1      = 3'd0;
    a2      = 3'd0;
    expect_val("r0_old", 0, 8'h00);
    expect_val("r0_no_bypass", 2, 8'h00);
    sample();
    @(negedge clk);
    wr = 1'b0;
    expect_val("r0_written", 0, 8'h12);
    expect_val("r0_zero_b1", 2, 8'h00);
    expect_val("r0_zero_b2", 3, 8'h00);
    sample();

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
